// File: rtl/packed_lane_acc_pkg.sv
// Shared types and constants for the packed multi-channel accumulator.
// The default-configuration views let benches decode the word by channel or by slice.
package packed_lane_acc_pkg;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    localparam int unsigned DEF_NUM_CH = 2;
    localparam int unsigned DEF_CH_W   = 16;
    localparam int unsigned DEF_NIB_W  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } snap_state_t;

    // Channel 0 is declared first, so it sits in the MSBs of the word
    typedef struct packed {
        bit [15:0] ch0;
        bit [15:0] ch1;
    } acc_word_t;

    typedef union packed {
        acc_word_t      ch;
        bit [7:0][3:0]  nib;
    } acc_view_t;

endpackage

// File: rtl/lane_acc_ch.sv
// One accumulator channel: widened add, carry-out and wrap/saturate result selection.
module lane_acc_ch
    import packed_lane_acc_pkg::*;
#(
    parameter int unsigned CH_W     = 16,
    parameter int unsigned SAT_MODE = MODE_WRAP
) (
    input  logic [CH_W-1:0] acc_i,
    input  logic [CH_W-1:0] step_i,
    input  logic            en_i,
    output logic [CH_W-1:0] next_c_o,
    output logic            carry_c_o
);

    logic [CH_W:0] sum_c;

    // A saturated channel with a nonzero step carries again, so it stays pinned and re-flags
    always_comb begin
        sum_c     = {1'b0, acc_i} + {1'b0, step_i};
        carry_c_o = en_i & sum_c[CH_W];
        next_c_o  = acc_i;
        if (en_i) begin
            if (sum_c[CH_W] && (SAT_MODE == MODE_SAT)) begin
                next_c_o = '1;
            end else begin
                next_c_o = sum_c[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/packed_lane_accumulator.sv
// Multi-channel accumulator held as one packed word, with per-slice writes,
// sticky overflow flags and a valid/ready snapshot port.
module packed_lane_accumulator
    import packed_lane_acc_pkg::*;
#(
    parameter  int unsigned NUM_CH    = DEF_NUM_CH,
    parameter  int unsigned CH_W      = DEF_CH_W,
    parameter  int unsigned NIB_W     = DEF_NIB_W,
    parameter  int unsigned SAT_MODE  = MODE_WRAP,
    localparam int unsigned TOT_W     = NUM_CH * CH_W,
    localparam int unsigned NUM_SLICE = TOT_W / NIB_W,
    localparam int unsigned SIDX_W    = (NUM_SLICE > 1) ? $clog2(NUM_SLICE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TOT_W-1:0]  step_i,
    input  logic [NUM_CH-1:0] acc_en_i,
    input  logic              slice_wr_i,
    input  logic [SIDX_W-1:0] slice_idx_i,
    input  logic [NIB_W-1:0]  slice_data_i,
    input  logic              clr_ovf_i,
    input  logic              snap_req_i,
    input  logic              snap_ready_i,
    output logic              snap_valid_o,
    output logic [TOT_W-1:0]  snap_data_o,
    output logic [TOT_W-1:0]  acc_o,
    output logic [NUM_CH-1:0] ovf_o
);

    localparam int unsigned SL_PER_CH = CH_W / NIB_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [TOT_W-1:0]     acc_q, acc_d;
    logic [NUM_CH-1:0]    ovf_q, ovf_d;
    logic [0:0]           state_q, state_d;
    logic                 snap_valid_q, snap_valid_d;
    logic [TOT_W-1:0]     snap_data_q, snap_data_d;

    logic [NUM_SLICE-1:0] slice_hit_c;
    logic [NUM_CH-1:0]    ch_hit_c;
    logic [NUM_CH-1:0]    carry_c;
    logic [TOT_W-1:0]     acc_sum_c;

    // An out-of-range index matches no slice, so the write simply vanishes
    always_comb begin
        slice_hit_c = '0;
        for (int unsigned s = 0; s < NUM_SLICE; s++) begin
            slice_hit_c[s] = slice_wr_i && (slice_idx_i == SIDX_W'(s));
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam int unsigned LSB = (NUM_CH - 1 - k) * CH_W;

        assign ch_hit_c[k] = |slice_hit_c[(NUM_CH-1-k)*SL_PER_CH +: SL_PER_CH];

        lane_acc_ch #(
            .CH_W     (CH_W),
            .SAT_MODE (SAT_MODE)
        ) u_lane (
            .acc_i     (acc_q[LSB +: CH_W]),
            .step_i    (step_i[LSB +: CH_W]),
            .en_i      (acc_en_i[k]),
            .next_c_o  (acc_sum_c[LSB +: CH_W]),
            .carry_c_o (carry_c[k])
        );
    end

    // A slice write freezes its whole channel for the cycle, then patches the slice
    always_comb begin
        acc_d = acc_sum_c;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_hit_c[k]) begin
                acc_d[(NUM_CH-1-k)*CH_W +: CH_W] = acc_q[(NUM_CH-1-k)*CH_W +: CH_W];
            end
        end
        for (int unsigned s = 0; s < NUM_SLICE; s++) begin
            if (slice_hit_c[s]) begin
                acc_d[s*NIB_W +: NIB_W] = slice_data_i;
            end
        end
        ovf_d = (clr_ovf_i ? '0 : ovf_q) | (carry_c & ~ch_hit_c);
    end

    // Snapshot handshake; capture always uses the pre-edge accumulator value
    always_comb begin
        state_d      = state_q;
        snap_valid_d = snap_valid_q;
        snap_data_d  = snap_data_q;
        case (state_q)
            ST_IDLE: begin
                if (snap_req_i) begin
                    snap_data_d  = acc_q;
                    snap_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (snap_ready_i) begin
                    if (snap_req_i) begin
                        snap_data_d = acc_q;
                    end else begin
                        snap_valid_d = 1'b0;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: begin
                snap_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            ovf_q        <= '0;
            state_q      <= ST_IDLE;
            snap_valid_q <= 1'b0;
            snap_data_q  <= '0;
        end else begin
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            snap_valid_q <= snap_valid_d;
            snap_data_q  <= snap_data_d;
        end
    end

    assign acc_o        = acc_q;
    assign ovf_o        = ovf_q;
    assign snap_valid_o = snap_valid_q;
    assign snap_data_o  = snap_data_q;

endmodule

// File: tb/tb_packed_lane_accumulator.sv
// Bench for packed_lane_accumulator: wrap, saturate and 12-bit-channel instances
// checked every cycle against an arithmetic model, plus hand-computed literals.
module tb_packed_lane_accumulator;
    import packed_lane_acc_pkg::*;

    typedef struct packed {
        logic [1:0][15:0] ch;
        logic [1:0]       ovf;
        logic             sval;
        logic [31:0]      sdata;
    } mst_t;

    logic clk;
    logic rst;

    // Stimulus shared by the wrap (a) and saturate (s) instances
    logic [31:0] step_a;
    logic [1:0]  en_a;
    logic        wr_a;
    logic [2:0]  idx_a;
    logic [3:0]  data_a;
    logic        clr_a, req_a, rdy_a;

    logic        sval_a, sval_s;
    logic [31:0] sdata_a, sdata_s, acc_a, acc_s;
    logic [1:0]  ovf_a, ovf_s;

    // 12-bit channel instance (b), six slices
    logic [23:0] step_b;
    logic [1:0]  en_b;
    logic        wr_b;
    logic [2:0]  idx_b;
    logic [3:0]  data_b;
    logic        zero_b;
    logic        sval_b;
    logic [23:0] sdata_b, acc_b;
    logic [1:0]  ovf_b;

    mst_t ma, ms, mb;
    logic run;
    int   total, bad;
    acc_view_t view;

    packed_lane_accumulator #(.SAT_MODE(MODE_WRAP)) u_dut_a (
        .clk(clk), .rst(rst), .step_i(step_a), .acc_en_i(en_a), .slice_wr_i(wr_a),
        .slice_idx_i(idx_a), .slice_data_i(data_a), .clr_ovf_i(clr_a), .snap_req_i(req_a),
        .snap_ready_i(rdy_a), .snap_valid_o(sval_a), .snap_data_o(sdata_a), .acc_o(acc_a),
        .ovf_o(ovf_a)
    );

    packed_lane_accumulator #(.SAT_MODE(MODE_SAT)) u_dut_s (
        .clk(clk), .rst(rst), .step_i(step_a), .acc_en_i(en_a), .slice_wr_i(wr_a),
        .slice_idx_i(idx_a), .slice_data_i(data_a), .clr_ovf_i(clr_a), .snap_req_i(req_a),
        .snap_ready_i(rdy_a), .snap_valid_o(sval_s), .snap_data_o(sdata_s), .acc_o(acc_s),
        .ovf_o(ovf_s)
    );

    packed_lane_accumulator #(.CH_W(12), .SAT_MODE(MODE_WRAP)) u_dut_b (
        .clk(clk), .rst(rst), .step_i(step_b), .acc_en_i(en_b), .slice_wr_i(wr_b),
        .slice_idx_i(idx_b), .slice_data_i(data_b), .clr_ovf_i(zero_b), .snap_req_i(zero_b),
        .snap_ready_i(zero_b), .snap_valid_o(sval_b), .snap_data_o(sdata_b), .acc_o(acc_b),
        .ovf_o(ovf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint unsigned mword(input mst_t s, input int chw);
        return (64'(s.ch[0]) << chw) | 64'(s.ch[1]);
    endfunction

    // Next state from the behavioural rules: channel 0 is the high field, slices count from the LSB
    function automatic mst_t mnext(input mst_t s, input int chw, input bit sat, input logic rst_in,
                                   input logic [31:0] step, input logic [1:0] en, input logic wr,
                                   input int idx, input logic [3:0] data, input logic clr,
                                   input logic req, input logic rdy);
        mst_t n;
        longint unsigned mask, sum, stp, w, old_w;
        int hit;
        logic [1:0] set;
        n     = s;
        mask  = (64'd1 << chw) - 64'd1;
        old_w = mword(s, chw);
        hit   = -1;
        set   = 2'b00;
        if (wr && idx < (2 * chw) / 4) hit = 1 - (idx * 4) / chw;
        for (int k = 0; k < 2; k++) begin
            if (en[k] && k != hit) begin
                stp = (64'(step) >> ((1 - k) * chw)) & mask;
                sum = 64'(s.ch[k]) + stp;
                if (sum > mask) begin
                    set[k] = 1'b1;
                    sum = sat ? mask : (sum & mask);
                end
                n.ch[k] = 16'(sum);
            end
        end
        if (hit >= 0) begin
            w = mword(n, chw);
            w = (w & ~(64'hF << (idx * 4))) | (64'(data) << (idx * 4));
            n.ch[0] = 16'((w >> chw) & mask);
            n.ch[1] = 16'(w & mask);
        end
        n.ovf = (clr ? 2'b00 : s.ovf) | set;
        if (!s.sval) begin
            if (req) begin
                n.sval  = 1'b1;
                n.sdata = 32'(old_w);
            end
        end else if (rdy) begin
            if (req) n.sdata = 32'(old_w);
            else     n.sval  = 1'b0;
        end
        if (rst_in) n = '0;
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= mnext(ma, 16, 1'b0, rst, step_a, en_a, wr_a, int'(idx_a), data_a, clr_a, req_a, rdy_a);
        ms <= mnext(ms, 16, 1'b1, rst, step_a, en_a, wr_a, int'(idx_a), data_a, clr_a, req_a, rdy_a);
        mb <= mnext(mb, 12, 1'b0, rst, 32'(step_b), en_b, wr_b, int'(idx_b), data_b,
                    1'b0, 1'b0, 1'b0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("a_acc",   acc_a,              32'(mword(ma, 16)));
            chk("a_ovf",   32'(ovf_a),         32'(ma.ovf));
            chk("a_sval",  32'(sval_a),        32'(ma.sval));
            chk("a_sdata", sdata_a,            ma.sdata);
            chk("s_acc",   acc_s,              32'(mword(ms, 16)));
            chk("s_ovf",   32'(ovf_s),         32'(ms.ovf));
            chk("s_sval",  32'(sval_s),        32'(ms.sval));
            chk("s_sdata", sdata_s,            ms.sdata);
            chk("b_acc",   32'(acc_b),         32'(mword(mb, 12)));
            chk("b_ovf",   32'(ovf_b),         32'(mb.ovf));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_slice(input int i, input logic [3:0] d);
        wr_a = 1'b1; idx_a = 3'(i); data_a = d;
        cyc();
        wr_a = 1'b0;
    endtask

    initial begin
        logic [3:0] fffe_nib [4];
        fffe_nib = '{4'hE, 4'hF, 4'hF, 4'hF};
        total = 0; bad = 0; run = 1'b0;
        rst = 1'b1;
        step_a = '0; en_a = '0; wr_a = 1'b0; idx_a = '0; data_a = '0;
        clr_a = 1'b0; req_a = 1'b0; rdy_a = 1'b0;
        step_b = '0; en_b = '0; wr_b = 1'b0; idx_b = '0; data_b = '0; zero_b = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        run = 1'b1;

        chk("rst_acc", acc_a, 32'h0);
        chk("rst_ovf", 32'(ovf_a), 32'h0);
        chk("rst_sval", 32'(sval_s), 32'h0);

        // Both channels accumulating from reset
        step_a = {16'd5, 16'd6}; en_a = 2'b11;
        repeat (10) cyc();
        chk("acc10_a", acc_a, 32'h0032_003C);
        chk("acc10_s", acc_s, 32'h0032_003C);
        chk("acc10_ovf", 32'(ovf_a), 32'h0);

        // Snapshot while accumulating, held against a stalled consumer
        req_a = 1'b1; cyc(); req_a = 1'b0;
        chk("snap_v", 32'(sval_a), 32'h1);
        chk("snap_d", sdata_a, 32'h0032_003C);
        repeat (5) cyc();
        chk("snap_hold_d", sdata_a, 32'h0032_003C);
        chk("snap_hold_acc", acc_a, 32'h0050_0060);
        req_a = 1'b1; rdy_a = 1'b1; cyc(); req_a = 1'b0;
        chk("b2b_v", 32'(sval_a), 32'h1);
        chk("b2b_d", sdata_a, 32'h0050_0060);
        cyc(); rdy_a = 1'b0;
        chk("done_v", 32'(sval_a), 32'h0);
        chk("done_d", sdata_a, 32'h0050_0060);

        // Whole word written slice by slice
        en_a = 2'b00;
        for (int i = 0; i < 8; i++) wr_slice(i, 4'(i));
        chk("slices_a", acc_a, 32'h7654_3210);
        chk("slices_s", acc_s, 32'h7654_3210);

        // Slice write into ch0 while both channels are enabled
        en_a = 2'b11; step_a = {16'd5, 16'd6};
        wr_slice(4, 4'hA);
        en_a = 2'b00;
        chk("slice4_acc", acc_a, 32'h765A_3216);
        view = acc_view_t'(acc_a);
        chk("slice4_nib", 32'(view.nib[4]), 32'hA);
        chk("slice4_ch1", 32'(view.ch.ch1), 32'h3216);

        // Carry out of ch1, then clear, then clear racing a new carry
        for (int i = 0; i < 4; i++) wr_slice(i, fffe_nib[i]);
        chk("fffe", acc_a, 32'h765A_FFFE);
        step_a = {16'd0, 16'd6}; en_a = 2'b10; cyc(); en_a = 2'b00;
        chk("wrap_ch1", 32'(acc_a[15:0]), 32'h0004);
        chk("wrap_ovf", 32'(ovf_a), 32'h2);
        chk("sat_ch1", 32'(acc_s[15:0]), 32'hFFFF);
        chk("sat_ovf", 32'(ovf_s), 32'h2);
        clr_a = 1'b1; cyc(); clr_a = 1'b0;
        chk("clr_a", 32'(ovf_a), 32'h0);
        chk("clr_s", 32'(ovf_s), 32'h0);
        step_a = {16'd0, 16'hFFFF}; en_a = 2'b10; clr_a = 1'b1; cyc(); clr_a = 1'b0;
        chk("clrrace_ovf_a", 32'(ovf_a), 32'h2);
        chk("clrrace_ch1_a", 32'(acc_a[15:0]), 32'h0003);
        chk("clrrace_ovf_s", 32'(ovf_s), 32'h2);
        repeat (5) cyc();
        en_a = 2'b00;
        chk("sat_hold", 32'(acc_s[15:0]), 32'hFFFF);

        // Zero step on a saturated channel raises nothing
        clr_a = 1'b1; cyc(); clr_a = 1'b0;
        step_a = '0; en_a = 2'b11; repeat (3) cyc(); en_a = 2'b00;
        chk("zero_step_ovf", 32'(ovf_s), 32'h0);
        chk("zero_step_ch1", 32'(acc_s[15:0]), 32'hFFFF);

        // 12-bit channels: six slices, out-of-range indices ignored
        for (int i = 0; i < 6; i++) begin
            wr_b = 1'b1; idx_b = 3'(i); data_b = 4'(i + 1);
            cyc();
        end
        wr_b = 1'b1; idx_b = 3'd7; data_b = 4'hF; cyc();
        wr_b = 1'b0;
        chk("b_slices", 32'(acc_b), 32'h0065_4321);
        step_b = {12'd1, 12'd2}; en_b = 2'b11; wr_b = 1'b1; idx_b = 3'd6; cyc();
        wr_b = 1'b0; en_b = 2'b00;
        chk("b_oor_acc", 32'(acc_b), 32'h0065_5323);

        // Reset while a snapshot is held
        req_a = 1'b1; cyc(); req_a = 1'b0;
        chk("hold_v", 32'(sval_a), 32'h1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_hold_v", 32'(sval_a), 32'h0);
        chk("rst_hold_d", sdata_a, 32'h0);
        chk("rst_hold_acc", acc_a, 32'h0);
        chk("rst_hold_ovf", 32'(ovf_a), 32'h0);
        cyc();

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packed_lane_accumulator.md
Name: packed_lane_accumulator

Overview:
Parametrised multi-channel accumulator whose state is held as one packed word. Each channel has an independent step and enable, and the word can also be written one fixed-width slice at a time. Wrap or saturate mode is selectable, overflow flags are sticky, and a valid/ready snapshot port hands a coherent copy of all channels to a consumer. Serves as the reusable stimulus/counter core for benches and datapaths that need both a per-channel view and a per-slice view of the same state.

Parameters:
NUM_CH, 2, number of accumulator channels
CH_W, 16, width of each channel in bits
NIB_W, 4, slice width for slice writes; CH_W must be a multiple of NIB_W
SAT_MODE, 0, 0 = modulo wrap, 1 = saturate at all-ones
Derived: TOT_W = NUM_CH*CH_W; NUM_SLICE = TOT_W/NIB_W; SIDX_W = max(1, $clog2(NUM_SLICE))

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
step_i  in  TOT_W  per-channel step value, same packing as acc_o
acc_en_i  in  NUM_CH  per-channel accumulate enable; bit k = channel k
slice_wr_i  in  1  write one slice this cycle
slice_idx_i  in  SIDX_W  slice index; slice i = acc bits [i*NIB_W +: NIB_W]
slice_data_i  in  NIB_W  slice write data
clr_ovf_i  in  1  clear all sticky overflow flags
snap_req_i  in  1  request a snapshot
snap_ready_i  in  1  consumer ready
snap_valid_o  out  1  snapshot valid
snap_data_o  out  TOT_W  snapshot word
acc_o  out  TOT_W  live accumulator word, registered
ovf_o  out  NUM_CH  sticky overflow flag per channel

Behaviour:
- Packing: channel k occupies bits [TOT_W-1-k*CH_W -: CH_W], so channel 0 is the MSBs (packed-struct member order). Slices are LSB-indexed, so slice 0 lies in channel NUM_CH-1.
- Reset (rst=1 at an edge): acc_o=0, ovf_o=0, snap_valid_o=0, snap_data_o=0, FSM=IDLE. Reset takes priority over all other inputs. A snapshot pending at reset is dropped.
- Accumulate: if acc_en_i[k]=1, channel k updates next edge to acc[k]+step[k], computed in CH_W+1 bits. Single-cycle latency.
- Carry-out: sets ovf_o[k]. The stored result is the low CH_W bits when SAT_MODE=0, and all-ones when SAT_MODE=1.
- Saturated hold: a channel already at all-ones with a nonzero step stays at all-ones and sets ovf_o[k]. A zero step never sets overflow.
- Slice write priority: slice_wr_i beats accumulation for the whole channel containing that slice.
  - That channel's other bits hold for the cycle.
  - Its ovf flag is not set by that cycle.
  - Other channels accumulate normally.
- Slice index out of range (slice_idx_i ≥ NUM_SLICE): the write is ignored and that cycle behaves as if slice_wr_i=0.
- Overflow flags: clr_ovf_i clears all flags. A flag being set in the same cycle as clr_ovf_i wins, so that flag ends at 1.
- Snapshot FSM, states IDLE and HOLD:
  - IDLE: snap_req_i=1 captures the acc_o value present at that edge (pre-update) into snap_data_o. snap_valid_o=1 from the next cycle. Go to HOLD.
  - HOLD: snap_data_o is stable while snap_valid_o=1 and snap_ready_i=0. snap_req_i without a handshake is ignored.
  - HOLD with snap_ready_i=1 and snap_req_i=0: transfer completes, snap_valid_o=0 next cycle, go to IDLE. snap_data_o keeps its last value.
  - HOLD with snap_ready_i=1 and snap_req_i=1: back-to-back transfer. Recapture the current acc_o, stay in HOLD, snap_valid_o stays 1.
- Snapshot capture is never affected by a slice write or accumulate occurring in the same cycle; it always takes the pre-edge value.

Decomposition:
- Package packed_lane_acc_pkg contains:
  - enum snap_state_t {IDLE, HOLD};
  - the default-configuration typedefs: packed struct {bit[15:0] ch0; bit[15:0] ch1;} and the packed union of that struct with bit[7:0][3:0], for bench-side decode;
  - localparams for mode encodings.
- Sub-module lane_acc_ch: one channel's CH_W+1-bit add, wrap/saturate selection and carry-out. Instantiated NUM_CH times through a generate loop. Slice muxing and the FSM stay in the top level.

Test Plan:
- Defaults, step ch0=5 and ch1=6, both enabled for 10 cycles from reset → acc_o=32'h0032_003C, ovf_o=2'b00.
- Enables low, slice writes i=0..7 with data=i → acc_o=32'h7654_3210. slice_idx_i=8 is not representable at defaults; use NUM_SLICE=6 (CH_W=12) with idx=7 → no change.
- SAT_MODE=0: set ch1=16'hFFFE, step 6, one enabled cycle → ch1=16'h0004, ovf_o[1]=1. A clr_ovf_i pulse → ovf_o=0. clr_ovf_i together with a new carry → ovf_o[1]=1.
- SAT_MODE=1, same stimulus → ch1=16'hFFFF, ovf_o[1]=1. A further 5 cycles → still 16'hFFFF.
- Snapshot: request when acc_o=32'h0032_003C with accumulation running; hold snap_ready_i=0 for 5 cycles → snap_valid_o=1 and snap_data_o constant. Then ready=1 with req=1 → recapture and valid stays 1. Then ready=1 with req=0 → valid=0 next cycle.
- Slice write to slice 4 (ch0) while ch0 and ch1 are enabled → ch0 changes only its nibble, ch1 accumulates. rst asserted in HOLD → all outputs 0 next cycle.
